tile_stim_checker: RTL and testbench

On-chip stimulus driver and response compactor for one microtile. It is the driving end of the tile's `ui_in`/`uo_out` interface: it generates an 8-bit input vector sequence on `tile_ui` and samples the tile's 8-bit `tile_uo` response after a programmable settle time. Responses are folded into a 16-bit MISR signature for a single-compare pass/fail check. It sits between the tile wrapper and the chip-level test controller, which starts a run and reads back the signature.

---
 rtl/tile_stim_checker.sv | 158 +++++++++++++++
 tb/tb_tile_stim_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tile_stim_checker.sv
// tile_stim_checker
//
// Stimulus driver and response compactor for one microtile. It drives an
// 8-bit vector sequence onto the tile's ui_in and samples the tile's uo_out
// once per vector, after the vector has been held SETTLE+1 cycles. Each
// sample is folded into a 16-bit MISR. The chip test controller compares
// the final signature against a single golden value.
//
// Parameters:
//   N_VEC   vectors per run (1..256)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      run request, honoured only when idle
//   mode       0 = counter vectors, 1 = LFSR vectors (latched at start)
//   tile_ui    stimulus vector to the tile
//   tile_uo    tile response
//   busy       high from the start edge up to, but not including, done
//   done       one-cycle pulse at the end of a run
//   vec_idx    index of the vector currently driven
//   signature  MISR result, held until the next start
//
// Build option:
//   TILE_CHK_UO_SYNC_EN  route tile_uo through a 2-flop synchronizer before
//                        it reaches the MISR. Sample edges do not move, so
//                        SETTLE must be at least 2 for each sample to see
//                        the vector it belongs to.

module tile_stim_checker #(
    parameter int N_VEC  = 256,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic [7:0]  tile_ui,
    input  logic [7:0]  tile_uo,
    output logic        busy,
    output logic        done,
    output logic [7:0]  vec_idx,
    output logic [15:0] signature
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [8:0] LAST_VEC  = 9'(N_VEC - 1);
    localparam logic [3:0] LAST_HOLD = 4'(SETTLE);

    logic [1:0] state;
    logic [3:0] hold_cnt;   // cycles the current vector has been held
    logic [8:0] vec_cnt;    // samples taken so far in this run
    logic       mode_q;
    logic [7:0] uo_s;       // response value seen by the MISR
    logic       sample;
    logic       last_vec;

    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [7:0]  din);
        logic [15:0] fb;
        fb = sig[15] ? 16'h100B : 16'h0000;
        return ({sig[14:0], 1'b0} ^ fb) ^ {8'h00, din};
    endfunction

    function automatic logic [7:0] next_vec(input logic [7:0] v,
                                            input logic       lfsr);
        if (lfsr)
            return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        else
            return v + 8'd1;
    endfunction

`ifdef TILE_CHK_UO_SYNC_EN
    logic [7:0] uo_p0;
    logic [7:0] uo_p1;

    // Synchronizer stages: response is two cycles old by the time it is used
    always_ff @(posedge clk) begin
        uo_p0 <= tile_uo;
        uo_p1 <= uo_p0;
    end

    assign uo_s = uo_p1;
`else
    assign uo_s = tile_uo;
`endif

    assign sample   = (state == S_RUN) && (hold_cnt == LAST_HOLD);
    assign last_vec = (vec_cnt == LAST_VEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= 4'd0;
            vec_cnt   <= 9'd0;
            mode_q    <= 1'b0;
            tile_ui   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_idx   <= 8'h00;
            signature <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        mode_q    <= mode;
                        hold_cnt  <= 4'd0;
                        vec_cnt   <= 9'd0;
                        tile_ui   <= mode ? 8'h01 : 8'h00;
                        vec_idx   <= 8'h00;
                        busy      <= 1'b1;
                        signature <= 16'hFFFF;
                    end
                end

                S_RUN: begin
                    if (sample) begin
                        signature <= misr_step(signature, uo_s);
                        hold_cnt  <= 4'd0;
                        if (last_vec) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            tile_ui <= 8'h00;
                            vec_idx <= 8'h00;
                        end else begin
                            vec_cnt <= vec_cnt + 9'd1;
                            tile_ui <= next_vec(tile_ui, mode_q);
                            vec_idx <= vec_idx + 8'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here; a held start
                    // is picked up in the following idle cycle
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_stim_checker.sv
module tb_tile_stim_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       mode;
    logic       start_a, start_b, start_c;
    logic [7:0] uo_a;

    logic [7:0]  ui_a, ui_b, ui_c;
    logic [7:0]  idx_a, idx_b, idx_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [15:0] sig_a, sig_b, sig_c;

    // Single-vector instance with externally driven response
    tile_stim_checker #(.N_VEC(1), .SETTLE(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode),
        .tile_ui(ui_a), .tile_uo(uo_a), .busy(busy_a), .done(done_a),
        .vec_idx(idx_a), .signature(sig_a)
    );

    // Short loopback instance
    tile_stim_checker #(.N_VEC(4), .SETTLE(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .tile_ui(ui_b), .tile_uo(ui_b), .busy(busy_b), .done(done_b),
        .vec_idx(idx_b), .signature(sig_b)
    );

    // Full-length loopback instance
    tile_stim_checker #(.N_VEC(256), .SETTLE(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode),
        .tile_ui(ui_c), .tile_uo(ui_c), .busy(busy_c), .done(done_c),
        .vec_idx(idx_c), .signature(sig_c)
    );

    int          sel;
    logic [7:0]  cur_ui, cur_idx;
    logic        cur_busy, cur_done;
    logic [15:0] cur_sig;

    always_comb begin
        cur_ui = ui_a; cur_idx = idx_a; cur_busy = busy_a;
        cur_done = done_a; cur_sig = sig_a;
        case (sel)
            1: begin
                cur_ui = ui_b; cur_idx = idx_b; cur_busy = busy_b;
                cur_done = done_b; cur_sig = sig_b;
            end
            2: begin
                cur_ui = ui_c; cur_idx = idx_c; cur_busy = busy_c;
                cur_done = done_c; cur_sig = sig_c;
            end
            default: ;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_ui_q[$];
    logic [7:0]  exp_idx_q[$];
    logic [15:0] exp_sig_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_misr(input logic [15:0] s,
                                               input logic [7:0] d);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ 16'h100B;
        return r ^ {8'h00, d};
    endfunction

    function automatic logic [7:0] model_next(input logic [7:0] v,
                                              input logic md);
        if (md) return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v + 8'd1;
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    // One run on instance d. Expected per-cycle vector/index and the final
    // signature are queued before start; the monitor loop pops them.
    task automatic run(input int d, input int nvec, input int settle,
                       input logic md, input bit noise, input int rst_at,
                       output logic [15:0] sig_out);
        logic [7:0]  v;
        logic [15:0] s;
        int          total;
        v = md ? 8'h01 : 8'h00;
        s = 16'hFFFF;
        for (int k = 0; k < nvec; k++) begin
            for (int h = 0; h <= settle; h++) begin
                exp_ui_q.push_back(v);
                exp_idx_q.push_back(8'(k));
            end
            s = model_misr(s, (d == 0) ? uo_a : v);
            v = model_next(v, md);
        end
        exp_sig_q.push_back(s);
        sig_out = s;
        total = nvec * (settle + 1);

        sel  = d;
        mode = md;
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, 1'b0);
        for (int c = 0; c < total; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            set_start(d, 1'b0);
            check($sformatf("ui_d%0d_c%0d", d, c), 32'(cur_ui), 32'(exp_ui_q.pop_front()));
            check($sformatf("idx_d%0d_c%0d", d, c), 32'(cur_idx), 32'(exp_idx_q.pop_front()));
            check($sformatf("busy_d%0d_c%0d", d, c), 32'(cur_busy), 32'd1);
            check($sformatf("done_d%0d_c%0d", d, c), 32'(cur_done), 32'd0);
            if (noise && c == 2) mode = ~md;
            if (noise && (c == 3 || c == 5)) set_start(d, 1'b1);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_mid_ui", 32'(cur_ui), 32'h00);
                check("rst_mid_busy", 32'(cur_busy), 32'd0);
                check("rst_mid_done", 32'(cur_done), 32'd0);
                check("rst_mid_idx", 32'(cur_idx), 32'h00);
                check("rst_mid_sig", 32'(cur_sig), 32'h0000);
                repeat (2) @(posedge clk);
                #1;
                check("rst_hold_done", 32'(cur_done), 32'd0);
                rst = 1'b0;
                exp_ui_q.delete();
                exp_idx_q.delete();
                exp_sig_q.delete();
                mode = md;
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        mode = md;
        check($sformatf("done_pulse_d%0d", d), 32'(cur_done), 32'd1);
        check($sformatf("done_busy_d%0d", d), 32'(cur_busy), 32'd0);
        check($sformatf("sig_d%0d", d), 32'(cur_sig), 32'(exp_sig_q.pop_front()));
        check($sformatf("done_ui_d%0d", d), 32'(cur_ui), 32'h00);
        check($sformatf("done_idx_d%0d", d), 32'(cur_idx), 32'h00);
        @(posedge clk); #1;
        check($sformatf("done_clr_d%0d", d), 32'(cur_done), 32'd0);
        check($sformatf("sig_hold_d%0d", d), 32'(cur_sig), 32'(s));
        check($sformatf("idle_busy_d%0d", d), 32'(cur_busy), 32'd0);
    endtask

    logic [15:0] clean_b, tmp;

    initial begin
        sel = 0; mode = 1'b0; uo_a = 8'h00;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ui_a", 32'(ui_a), 32'h00);
        check("rst_ui_b", 32'(ui_b), 32'h00);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_done_c", 32'(done_c), 32'd0);
        check("rst_idx_c", 32'(idx_c), 32'h00);
        check("rst_sig_a", 32'(sig_a), 32'h0000);
        check("rst_sig_c", 32'(sig_c), 32'h0000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single vector, zero response, then 0xA5 response
        run(0, 1, 0, 1'b0, 1'b0, -1, tmp);
        check("a_sig_zero_resp", 32'(sig_a), 32'hEFF5);
        uo_a = 8'hA5;
        repeat (4) @(posedge clk);
        #1;
        run(0, 1, 0, 1'b0, 1'b0, -1, tmp);
        check("a_sig_a5_resp", 32'(sig_a), 32'hEF50);

        // Counter loopback, clean then with ignored start pulses and a mode flip
        run(1, 4, 2, 1'b0, 1'b0, -1, clean_b);
        run(1, 4, 2, 1'b0, 1'b1, -1, tmp);
        check("b_noise_sig_vs_clean", 32'(sig_b), 32'(clean_b));

        // LFSR loopback on the short instance
        run(1, 4, 2, 1'b1, 1'b0, -1, tmp);

        // Abort by reset at cycle 5, then a clean rerun
        run(1, 4, 2, 1'b0, 1'b0, 5, tmp);
        run(1, 4, 2, 1'b0, 1'b0, -1, tmp);
        check("b_rerun_sig_vs_clean", 32'(sig_b), 32'(clean_b));

        // Full-length runs: complete LFSR sequence and counter wrap
        run(2, 256, 2, 1'b1, 1'b0, -1, tmp);
        run(2, 256, 2, 1'b0, 1'b0, -1, tmp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
